// File: rtl/issue_rat_rename_pkg.sv
// issue_rat_rename_pkg: shared sizes and RAT entry record for the rename stage
package issue_rat_rename_pkg;
  localparam int RAT_ARCH_REGS = 32;
  localparam int RAT_PRF_WIDTH = 6;
  typedef struct packed {
    logic                     mapped;
    logic [RAT_PRF_WIDTH-1:0] prf;
  } rat_entry_t;
endpackage

// File: rtl/issue_rat_table.sv
// issue_rat_table: flop-based RAT with two read ports, one write port and a bulk load
module issue_rat_table
  import issue_rat_rename_pkg::*;
#(
  parameter int N  = RAT_ARCH_REGS,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  output rat_entry_t    rd0,
  output rat_entry_t    rd1,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  rat_entry_t    wd,
  input  logic          load,
  input  rat_entry_t    load_data [N],
  output rat_entry_t    dump [N]
);
  rat_entry_t mem [N];
  // reset clears every entry; a bulk load overrides any single write
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < N; i++) mem[i] <= '0;
    else if (load)
      mem <= load_data;
    else if (we)
      mem[wa] <= wd;
  assign rd0  = mem[ra0];
  assign rd1  = mem[ra1];
  assign dump = mem;
endmodule

// File: rtl/issue_rat_rename.sv
// issue_rat_rename: register rename using speculative and architectural RATs
module issue_rat_rename
  import issue_rat_rename_pkg::*;
#(
  parameter int ARCH_REGS = RAT_ARCH_REGS,
  parameter int PRF_WIDTH = RAT_PRF_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_rename_valid,
  output logic                         o_rename_ready,
  input  logic [$clog2(ARCH_REGS)-1:0] i_rename_rs1,
  input  logic [$clog2(ARCH_REGS)-1:0] i_rename_rs2,
  input  logic [$clog2(ARCH_REGS)-1:0] i_rename_rd,
  input  logic                         i_rename_rd_en,
  input  logic [PRF_WIDTH-1:0]         i_acquire_prf,
  input  logic                         i_acquire_valid,
  output logic                         o_acquire_ready,
  output logic                         o_renamed_valid,
  input  logic                         i_renamed_ready,
  output logic [PRF_WIDTH-1:0]         o_renamed_prs1,
  output logic [PRF_WIDTH-1:0]         o_renamed_prs2,
  output logic [PRF_WIDTH-1:0]         o_renamed_prd,
  output logic [PRF_WIDTH-1:0]         o_renamed_old_prd,
  output logic                         o_renamed_prs1_mapped,
  output logic                         o_renamed_prs2_mapped,
  output logic                         o_renamed_old_prd_valid,
  output logic                         o_renamed_prd_en,
  input  logic                         i_commit_valid,
  input  logic [$clog2(ARCH_REGS)-1:0] i_commit_rd,
  input  logic [PRF_WIDTH-1:0]         i_commit_prd,
  input  logic                         i_flush
);
  localparam int AW = $clog2(ARCH_REGS);
  logic       alloc, fire, arch_we, unused_arch;
  rat_entry_t spec_rs1, spec_rs2, spec_old, arch_rd0, arch_rd1, new_entry, commit_entry;
  rat_entry_t spec_dump [ARCH_REGS];
  rat_entry_t arch_dump [ARCH_REGS];
  rat_entry_t arch_next [ARCH_REGS];
  assign alloc           = i_rename_rd_en & (i_rename_rd != '0);
  assign o_rename_ready  = ~reset & ~i_flush & (~o_renamed_valid | i_renamed_ready);
  assign fire            = i_rename_valid & o_rename_ready & (~alloc | i_acquire_valid);
  assign o_acquire_ready = fire & alloc;
  assign arch_we         = i_commit_valid & (i_commit_rd != '0);
  assign new_entry       = '{mapped: 1'b1, prf: i_acquire_prf};
  assign commit_entry    = '{mapped: 1'b1, prf: i_commit_prd};
  assign spec_old        = spec_dump[i_rename_rd];
  assign unused_arch     = ^{arch_rd0, arch_rd1};
  // flush restores from the architectural state as it will be after this cycle's commit
  always_comb
    for (int i = 0; i < ARCH_REGS; i++)
      arch_next[i] = (arch_we && i_commit_rd == AW'(i)) ? commit_entry : arch_dump[i];
  issue_rat_table #(.N(ARCH_REGS)) u_spec_rat (
    .clk      (clk),
    .reset    (reset),
    .ra0      (i_rename_rs1),
    .ra1      (i_rename_rs2),
    .rd0      (spec_rs1),
    .rd1      (spec_rs2),
    .we       (fire & alloc),
    .wa       (i_rename_rd),
    .wd       (new_entry),
    .load     (i_flush),
    .load_data(arch_next),
    .dump     (spec_dump)
  );
  issue_rat_table #(.N(ARCH_REGS)) u_arch_rat (
    .clk      (clk),
    .reset    (reset),
    .ra0      (i_commit_rd),
    .ra1      (i_commit_rd),
    .rd0      (arch_rd0),
    .rd1      (arch_rd1),
    .we       (arch_we),
    .wa       (i_commit_rd),
    .wd       (commit_entry),
    .load     (1'b0),
    .load_data(arch_next),
    .dump     (arch_dump)
  );
  // output stage: load on fire, hold while stalled, drop valid on flush or drain
  always_ff @(posedge clk)
    if (reset) begin
      o_renamed_valid         <= 1'b0;
      o_renamed_prs1          <= '0;
      o_renamed_prs2          <= '0;
      o_renamed_prd           <= '0;
      o_renamed_old_prd       <= '0;
      o_renamed_prs1_mapped   <= 1'b0;
      o_renamed_prs2_mapped   <= 1'b0;
      o_renamed_old_prd_valid <= 1'b0;
      o_renamed_prd_en        <= 1'b0;
    end else if (i_flush)
      o_renamed_valid <= 1'b0;
    else if (fire) begin
      o_renamed_valid         <= 1'b1;
      o_renamed_prs1          <= spec_rs1.prf;
      o_renamed_prs2          <= spec_rs2.prf;
      o_renamed_prs1_mapped   <= spec_rs1.mapped;
      o_renamed_prs2_mapped   <= spec_rs2.mapped;
      o_renamed_prd_en        <= alloc;
      o_renamed_prd           <= alloc ? i_acquire_prf : '0;
      o_renamed_old_prd       <= alloc ? spec_old.prf : '0;
      o_renamed_old_prd_valid <= alloc & spec_old.mapped;
    end else if (i_renamed_ready)
      o_renamed_valid <= 1'b0;
endmodule

// File: tb/tb_issue_rat_rename.sv
// tb_issue_rat_rename: directed self-checking bench for the rename stage
module tb_issue_rat_rename;
  logic       clk = 1'b0, reset;
  logic       i_rename_valid, o_rename_ready, i_rename_rd_en;
  logic [4:0] i_rename_rs1, i_rename_rs2, i_rename_rd;
  logic [5:0] i_acquire_prf;
  logic       i_acquire_valid, o_acquire_ready;
  logic       o_renamed_valid, i_renamed_ready;
  logic [5:0] o_renamed_prs1, o_renamed_prs2, o_renamed_prd, o_renamed_old_prd;
  logic       o_renamed_prs1_mapped, o_renamed_prs2_mapped, o_renamed_old_prd_valid, o_renamed_prd_en;
  logic       i_commit_valid;
  logic [4:0] i_commit_rd;
  logic [5:0] i_commit_prd;
  logic       i_flush;
  int         checks = 0, failures = 0;

  always #5 clk = ~clk;

  issue_rat_rename dut (
    .clk(clk), .reset(reset),
    .i_rename_valid(i_rename_valid), .o_rename_ready(o_rename_ready),
    .i_rename_rs1(i_rename_rs1), .i_rename_rs2(i_rename_rs2), .i_rename_rd(i_rename_rd),
    .i_rename_rd_en(i_rename_rd_en),
    .i_acquire_prf(i_acquire_prf), .i_acquire_valid(i_acquire_valid), .o_acquire_ready(o_acquire_ready),
    .o_renamed_valid(o_renamed_valid), .i_renamed_ready(i_renamed_ready),
    .o_renamed_prs1(o_renamed_prs1), .o_renamed_prs2(o_renamed_prs2),
    .o_renamed_prd(o_renamed_prd), .o_renamed_old_prd(o_renamed_old_prd),
    .o_renamed_prs1_mapped(o_renamed_prs1_mapped), .o_renamed_prs2_mapped(o_renamed_prs2_mapped),
    .o_renamed_old_prd_valid(o_renamed_old_prd_valid), .o_renamed_prd_en(o_renamed_prd_en),
    .i_commit_valid(i_commit_valid), .i_commit_rd(i_commit_rd), .i_commit_prd(i_commit_prd),
    .i_flush(i_flush)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, rs2, rd, input logic en, input logic [5:0] prf);
    i_rename_valid  = 1'b1;
    i_rename_rs1    = rs1;
    i_rename_rs2    = rs2;
    i_rename_rd     = rd;
    i_rename_rd_en  = en;
    i_acquire_prf   = prf;
    i_acquire_valid = 1'b1;
  endtask

  task automatic idle;
    i_rename_valid  = 1'b0;
    i_acquire_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; i_flush = 1'b0; i_commit_valid = 1'b0; i_commit_rd = '0; i_commit_prd = '0;
    i_renamed_ready = 1'b1;
    idle();
    drive(0, 0, 0, 0, 0);
    idle();
    step(); step();
    drive(1, 2, 3, 1, 9);
    #1;
    check("rst_acq_ready", o_acquire_ready, 0);
    check("rst_ren_ready", o_rename_ready, 0);
    step();
    check("rst_valid", o_renamed_valid, 0);
    check("rst_prd", o_renamed_prd, 0);
    idle();
    reset = 1'b0;
    step();
    // first rename after reset
    drive(1, 2, 3, 1, 10);
    #1;
    check("t1_acq_ready", o_acquire_ready, 1);
    step();
    idle();
    check("t1_valid", o_renamed_valid, 1);
    check("t1_prs1_mapped", o_renamed_prs1_mapped, 0);
    check("t1_prs2_mapped", o_renamed_prs2_mapped, 0);
    check("t1_prd", o_renamed_prd, 10);
    check("t1_prd_en", o_renamed_prd_en, 1);
    check("t1_old_valid", o_renamed_old_prd_valid, 0);
    // same rd chained, source reads the old mapping
    drive(3, 0, 3, 1, 11);
    step();
    idle();
    check("t2_prs1", o_renamed_prs1, 10);
    check("t2_prs1_mapped", o_renamed_prs1_mapped, 1);
    check("t2_old_prd", o_renamed_old_prd, 10);
    check("t2_old_valid", o_renamed_old_prd_valid, 1);
    check("t2_prd", o_renamed_prd, 11);
    // rd = x0 never acquires
    drive(3, 0, 0, 1, 12);
    #1;
    check("t3_acq_ready", o_acquire_ready, 0);
    check("t3_ren_ready", o_rename_ready, 1);
    step();
    idle();
    check("t3_valid", o_renamed_valid, 1);
    check("t3_prd_en", o_renamed_prd_en, 0);
    check("t3_prd", o_renamed_prd, 0);
    check("t3_prs1", o_renamed_prs1, 11);
    // allocation waits for the free list
    drive(0, 0, 4, 1, 13);
    i_acquire_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t4_acq_wait", o_acquire_ready, 0);
      step();
      check("t4_no_fire", o_renamed_valid, 0);
    end
    i_acquire_valid = 1'b1;
    #1;
    check("t4_acq_ready", o_acquire_ready, 1);
    step();
    check("t4_valid", o_renamed_valid, 1);
    check("t4_prd", o_renamed_prd, 13);
    // downstream stall holds the output register
    i_renamed_ready = 1'b0;
    drive(0, 0, 7, 1, 14);
    for (int k = 0; k < 2; k++) begin
      #1;
      check("t5_ren_ready", o_rename_ready, 0);
      check("t5_acq_ready", o_acquire_ready, 0);
      step();
      check("t5_hold_valid", o_renamed_valid, 1);
      check("t5_hold_prd", o_renamed_prd, 13);
    end
    i_renamed_ready = 1'b1;
    #1;
    check("t5_acq_release", o_acquire_ready, 1);
    step();
    idle();
    check("t5_prd", o_renamed_prd, 14);
    check("t5_old_valid", o_renamed_old_prd_valid, 0);
    // reset during a stall drops the held instruction
    i_renamed_ready = 1'b0;
    drive(0, 0, 8, 1, 15);
    reset = 1'b1;
    #1;
    check("t6_acq_ready", o_acquire_ready, 0);
    step();
    check("t6_valid", o_renamed_valid, 0);
    check("t6_prd", o_renamed_prd, 0);
    check("t6_prd_en", o_renamed_prd_en, 0);
    reset = 1'b0;
    idle();
    i_renamed_ready = 1'b1;
    step();
    drive(3, 0, 0, 0, 0);
    step();
    idle();
    check("t6_rat_cleared", o_renamed_prs1_mapped, 0);
    check("t6_rat_prf", o_renamed_prs1, 0);
    // commit, speculative remap, then flush with a same-cycle commit
    i_commit_valid = 1'b1; i_commit_rd = 5; i_commit_prd = 20;
    step();
    i_commit_valid = 1'b0;
    drive(0, 0, 5, 1, 21);
    step();
    idle();
    check("t7_spec_prd", o_renamed_prd, 21);
    check("t7_spec_old_valid", o_renamed_old_prd_valid, 0);
    i_commit_valid = 1'b1; i_commit_rd = 6; i_commit_prd = 22;
    i_flush = 1'b1;
    drive(5, 6, 0, 0, 0);
    #1;
    check("t7_flush_ren_ready", o_rename_ready, 0);
    check("t7_flush_acq_ready", o_acquire_ready, 0);
    step();
    check("t7_flush_valid", o_renamed_valid, 0);
    i_commit_valid = 1'b0;
    i_flush = 1'b0;
    step();
    idle();
    check("t7_valid", o_renamed_valid, 1);
    check("t7_prs1", o_renamed_prs1, 20);
    check("t7_prs1_mapped", o_renamed_prs1_mapped, 1);
    check("t7_prs2", o_renamed_prs2, 22);
    check("t7_prs2_mapped", o_renamed_prs2_mapped, 1);
    check("t7_prd_en", o_renamed_prd_en, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/issue_rat_rename.md
ISSUE_RAT_RENAME -- requirements
Module: issue_rat_rename

Interface
REQ-001 SHALL have parameter ARCH_REGS, default 32, architectural register count (x0 included).
REQ-002 SHALL have parameter PRF_WIDTH, default 6, physical register index width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports i_rename_valid input 1, o_rename_ready output 1, i_rename_rs1/i_rename_rs2/i_rename_rd input 5 each, i_rename_rd_en input 1: decoded instruction in.
REQ-006 SHALL have ports i_acquire_prf input 6, i_acquire_valid input 1, o_acquire_ready output 1: free-list acquire handshake.
REQ-007 SHALL have ports o_renamed_valid output 1, i_renamed_ready input 1, o_renamed_prs1/o_renamed_prs2/o_renamed_prd/o_renamed_old_prd output 6 each, o_renamed_prs1_mapped/o_renamed_prs2_mapped/o_renamed_old_prd_valid/o_renamed_prd_en output 1 each: renamed instruction out.
REQ-008 SHALL have ports i_commit_valid input 1, i_commit_rd input 5, i_commit_prd input 6: retirement update of architectural RAT.
REQ-009 SHALL have port i_flush input 1: restore speculative RAT from architectural RAT.

Function
REQ-010 Two tables SHALL exist: speculative RAT and architectural RAT, each ARCH_REGS entries of {mapped, prf[5:0]}.
REQ-011 alloc SHALL equal i_rename_rd_en & (i_rename_rd != 0); x0 never allocates nor remaps.
REQ-012 Rename fire SHALL equal i_rename_valid & o_rename_ready & (~alloc | i_acquire_valid).
REQ-013 o_rename_ready SHALL equal ~i_flush & (~o_renamed_valid | i_renamed_ready).
REQ-014 o_acquire_ready SHALL equal fire & alloc; never asserted without a consumed rename.
REQ-015 On fire, sources SHALL read the speculative RAT before the same-cycle rd update (instruction reading its own rd sees the old mapping).
REQ-016 On fire with alloc, spec RAT[rd] SHALL become {1, i_acquire_prf} next cycle; old_prd/old_prd_valid capture the prior entry.
REQ-017 Output register SHALL load on fire (latency 1), hold while o_renamed_valid & ~i_renamed_ready, clear valid when drained with no fire.
REQ-018 o_renamed_prd_en SHALL equal captured alloc; o_renamed_prd SHALL be 0 when prd_en is 0.
REQ-019 Commit SHALL write arch RAT[i_commit_rd] = {1, i_commit_prd} when i_commit_valid & i_commit_rd != 0.
REQ-020 Flush SHALL clear o_renamed_valid and copy arch RAT (including same-cycle commit) into spec RAT next cycle; no fire in the flush cycle.
REQ-021 Back-to-back renames of same rd SHALL chain: second old_prd equals first prd.
REQ-022 Output register contents SHALL remain stable while stalled (valid & ~ready).

Reset
REQ-023 Reset SHALL clear all mapped bits and prf fields in both RATs to 0.
REQ-024 Reset SHALL drive o_renamed_valid=0, all o_renamed_* fields 0, o_acquire_ready=0; reset dominates flush and commit.
REQ-025 Reset mid-stall SHALL discard the held instruction without acquiring.

Structure
REQ-026 ARCH_REGS, PRF_WIDTH and the RAT entry record SHALL live in the shared issue package.
REQ-027 One sub-module issue_rat_table (flop-based, 2 read + 1 write + bulk load) SHALL be instanced twice; bulk load used only by spec RAT.

Verification
REQ-028 After reset, rename rs1=1 rs2=2 rd=3, acquire prf=10 -> next cycle valid, prs*_mapped=0, prd=10, old_prd_valid=0.
REQ-029 Rename rd=3 (prf 10) then rd=3 rs1=3 (prf 11) -> second: prs1=10, old_prd=10, prd=11.
REQ-030 rd=0 with rd_en=1, i_acquire_valid=1 -> o_acquire_ready=0, prd_en=0, fire without acquire.
REQ-031 alloc, i_acquire_valid=0 for 3 cycles -> no fire, o_acquire_ready=0; fires cycle acquire valid rises.
REQ-032 i_renamed_ready=0 for 2 cycles with new request pending -> outputs held, o_rename_ready=0, no acquire.
REQ-033 Commit rd=5 prf=20, spec rd=5 to 21, flush same cycle as commit rd=6 prf=22 -> next rename rs1=5 gives 20, rs2=6 gives 22, output valid cleared.
